// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// usb_pkg : PID, drop-reason and RX-buffer FSM types shared with the RX decoder.
// Rev 1.0
// ============================================================================
package usb_pkg;

  typedef enum logic [3:0] {
    PID_RSVD  = 4'b0000,
    PID_OUT   = 4'b0001,
    PID_ACK   = 4'b0010,
    PID_DATA0 = 4'b0011,
    PID_PING  = 4'b0100,
    PID_SOF   = 4'b0101,
    PID_NYET  = 4'b0110,
    PID_DATA2 = 4'b0111,
    PID_SPLIT = 4'b1000,
    PID_IN    = 4'b1001,
    PID_NAK   = 4'b1010,
    PID_DATA1 = 4'b1011,
    PID_PRE   = 4'b1100,
    PID_SETUP = 4'b1101,
    PID_STALL = 4'b1110,
    PID_MDATA = 4'b1111
  } pid_t;

  typedef enum logic [1:0] {
    DROP_CRC       = 2'd0,
    DROP_OVERFLOW  = 2'd1,
    DROP_RUNT      = 2'd2,
    DROP_NOT_ARMED = 2'd3
  } drop_reason_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_TOKEN   = 3'd2,
    S_DATA    = 3'd3,
    S_HS      = 3'd4,
    S_DISCARD = 3'd5,
    S_SOF     = 3'd6
  } state_t;

  localparam int c_crc_bytes = 2;

  // SOF only gets its own path when the SOF feature is built in.
  function automatic state_t classify(input pid_t pid);
    case (pid)
      PID_OUT, PID_IN, PID_SETUP, PID_PING:       return S_TOKEN;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: return S_DATA;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:      return S_HS;
`ifdef USB_RX_BUF_SOF_EN
      PID_SOF:                                    return S_SOF;
`endif
      default:                                    return S_DISCARD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// usb_rx_byte_fifo : 2**AW x 9 payload RAM, single write port, async read at rd.
// Rev 1.0
// ============================================================================
module usb_rx_byte_fifo #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [8:0]    wr_data,
  input  logic [AW-1:0] cmt_ptr,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic          rd_last,
  output logic [AW-1:0] rd_ptr
);

  logic [8:0]    r_mem [0:(2**AW)-1];
  logic [AW-1:0] r_rd;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 r_rd <= '0;
    else if (rd_valid && rd_ready) r_rd <= r_rd + AW'(1);
  end

  assign rd_valid           = (r_rd != cmt_ptr);
  assign {rd_last, rd_data} = r_mem[r_rd];
  assign rd_ptr             = r_rd;

endmodule
`default_nettype wire

// File: rtl/usb_rx_pkt_buffer.sv
`default_nettype none
// ============================================================================
// usb_rx_pkt_buffer : token filter + CRC-gated DATA payload buffer for USB RX.
// Optional SOF event output enabled by USB_RX_BUF_SOF_EN.   Rev 1.0
// ============================================================================
module usb_rx_pkt_buffer
  import usb_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  cfg_dev_addr,
  input  logic [7:0]  pkt_data,
  input  logic        pkt_valid,
  input  logic        pkt_sop,
  input  logic        pkt_eop,
  input  logic [3:0]  pkt_pid,
  input  logic [6:0]  pkt_dev_addr,
  input  logic [3:0]  pkt_endp,
  input  logic        pkt_crc_valid,
  output logic        tok_valid,
  output logic [3:0]  tok_pid,
  output logic [3:0]  tok_endp,
  output logic        hs_valid,
  output logic [3:0]  hs_pid,
  output logic        pkt_done,
  output logic [9:0]  pkt_len,
  output logic        pkt_data1,
  output logic        pkt_drop,
  output logic [1:0]  drop_reason,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        sof_valid,
  output logic [10:0] sof_frame
);

  state_t          r_state;
  logic [AW-1:0]   r_wr, r_cmt, w_rd;
  logic [9:0]      r_len;
  logic [2:0][7:0] r_sh;
  logic [1:0]      r_tcnt;
  logic            r_ovf, r_armed;

  pid_t            w_pid;
  state_t          w_cls;
  logic            w_active, w_byte, w_eop, w_full, w_tok_ok, w_good;
  drop_reason_t    w_reason;
  logic            w_we;
  logic [AW-1:0]   w_waddr, w_wr_p1, w_wr_m2, w_wr_m3;
  logic [8:0]      w_wdata;

  // In HDR the packet type is decided from the PID for the byte (or eop) at hand.
  assign w_pid    = pid_t'(pkt_pid);
  assign w_cls    = (r_state == S_HDR) ? classify(w_pid) : r_state;
  assign w_active = (r_state != S_IDLE);
  assign w_byte   = pkt_valid && !pkt_sop && w_active;
  assign w_eop    = pkt_eop && w_active;
  assign w_wr_p1  = r_wr + AW'(1);
  assign w_wr_m2  = r_wr - AW'(c_crc_bytes);
  assign w_wr_m3  = r_wr - AW'(c_crc_bytes + 1);
  assign w_full   = (w_wr_p1 == w_rd);
  assign w_tok_ok = (r_tcnt == 2'd2) && pkt_crc_valid;
  assign w_good   = r_armed && !r_ovf && (r_len >= 10'd2) && pkt_crc_valid;

  always_comb begin
    w_reason = DROP_CRC;
    if (!r_armed)            w_reason = DROP_NOT_ARMED;
    else if (r_ovf)          w_reason = DROP_OVERFLOW;
    else if (r_len < 10'd2)  w_reason = DROP_RUNT;
  end

  // Commit reuses the idle write port to tag the final payload byte as last.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_wr;
    w_wdata = {1'b0, pkt_data};
    if (w_byte && (w_cls == S_DATA) && !r_ovf && !w_full) begin
      w_we = 1'b1;
    end else if (w_eop && (w_cls == S_DATA) && w_good && (r_len >= 10'd3)) begin
      w_we    = 1'b1;
      w_waddr = w_wr_m3;
      w_wdata = {1'b1, r_sh[2]};
    end
  end

`ifdef USB_RX_BUF_SOF_EN
  logic        r_sof_valid;
  logic [10:0] r_sof_frame;
  assign sof_valid = r_sof_valid;
  assign sof_frame = r_sof_frame;
`else
  assign sof_valid = 1'b0;
  assign sof_frame = 11'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr        <= '0;
      r_cmt       <= '0;
      r_len       <= '0;
      r_sh        <= '0;
      r_tcnt      <= '0;
      r_ovf       <= 1'b0;
      r_armed     <= 1'b0;
      tok_valid   <= 1'b0;
      tok_pid     <= '0;
      tok_endp    <= '0;
      hs_valid    <= 1'b0;
      hs_pid      <= '0;
      pkt_done    <= 1'b0;
      pkt_len     <= '0;
      pkt_data1   <= 1'b0;
      pkt_drop    <= 1'b0;
      drop_reason <= '0;
`ifdef USB_RX_BUF_SOF_EN
      r_sof_valid <= 1'b0;
      r_sof_frame <= '0;
`endif
    end else begin
      tok_valid <= 1'b0;
      hs_valid  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_drop  <= 1'b0;
`ifdef USB_RX_BUF_SOF_EN
      r_sof_valid <= 1'b0;
`endif
      if (pkt_valid && pkt_sop) begin
        if (w_active) r_wr <= r_cmt;
        r_state <= S_HDR;
        r_len   <= '0;
        r_tcnt  <= '0;
        r_ovf   <= 1'b0;
      end else if (w_byte) begin
        r_state <= w_cls;
        if ((w_cls == S_TOKEN) || (w_cls == S_SOF)) begin
          if (r_tcnt != 2'd3) r_tcnt <= r_tcnt + 2'd1;
        end else if (w_cls == S_DATA) begin
          r_sh <= {r_sh[1:0], pkt_data};
          if (r_ovf || w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_wr  <= w_wr_p1;
            r_len <= r_len + 10'd1;
          end
        end
      end else if (w_eop) begin
        r_state <= S_IDLE;
        case (w_cls)
          S_TOKEN: begin
            if (w_tok_ok && (pkt_dev_addr == cfg_dev_addr)) begin
              tok_valid <= 1'b1;
              tok_pid   <= pkt_pid;
              tok_endp  <= pkt_endp;
              r_armed   <= (w_pid == PID_OUT) || (w_pid == PID_SETUP);
            end
          end
          S_DATA: begin
            r_armed <= 1'b0;
            if (w_good) begin
              r_wr      <= w_wr_m2;
              r_cmt     <= w_wr_m2;
              pkt_done  <= 1'b1;
              pkt_len   <= r_len - 10'd2;
              pkt_data1 <= (w_pid == PID_DATA1);
            end else begin
              r_wr        <= r_cmt;
              pkt_drop    <= 1'b1;
              drop_reason <= w_reason;
            end
          end
          S_HS: begin
            hs_valid <= 1'b1;
            hs_pid   <= pkt_pid;
          end
`ifdef USB_RX_BUF_SOF_EN
          S_SOF: begin
            if (w_tok_ok) begin
              r_sof_valid <= 1'b1;
              r_sof_frame <= {pkt_endp, pkt_dev_addr};
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  usb_rx_byte_fifo #(.AW(AW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (w_we),
    .wr_addr  (w_waddr),
    .wr_data  (w_wdata),
    .cmt_ptr  (r_cmt),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_ptr   (w_rd)
  );

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_pkt_buffer.sv
`default_nettype none
// ============================================================================
// tb_usb_rx_pkt_buffer : scoreboard bench, directed USB RX packets, AW=4 FIFO.
// Rev 1.0
// ============================================================================
module tb_usb_rx_pkt_buffer;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  cfg_dev_addr;
  logic [7:0]  pkt_data;
  logic        pkt_valid, pkt_sop, pkt_eop;
  logic [3:0]  pkt_pid;
  logic [6:0]  pkt_dev_addr;
  logic [3:0]  pkt_endp;
  logic        pkt_crc_valid;
  logic        tok_valid;
  logic [3:0]  tok_pid, tok_endp;
  logic        hs_valid;
  logic [3:0]  hs_pid;
  logic        pkt_done;
  logic [9:0]  pkt_len;
  logic        pkt_data1, pkt_drop;
  logic [1:0]  drop_reason;
  logic [7:0]  rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        sof_valid;
  logic [10:0] sof_frame;

  always #5 clk = ~clk;

  usb_rx_pkt_buffer #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_dev_addr(cfg_dev_addr),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_pid(pkt_pid), .pkt_dev_addr(pkt_dev_addr), .pkt_endp(pkt_endp),
    .pkt_crc_valid(pkt_crc_valid),
    .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_endp(tok_endp),
    .hs_valid(hs_valid), .hs_pid(hs_pid),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_data1(pkt_data1),
    .pkt_drop(pkt_drop), .drop_reason(drop_reason),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .sof_valid(sof_valid), .sof_frame(sof_frame)
  );

  localparam logic [3:0] OUT = 4'b0001, IN = 4'b1001, ACK = 4'b0010, NAK = 4'b1010;
  localparam logic [3:0] DATA0 = 4'b0011, DATA1 = 4'b1011, SOF = 4'b0101, PRE = 4'b1100;

  // event word: {kind, pid, endp, len, data1, reason, frame}
  typedef logic [34:0] ev_t;
  ev_t        exp_ev[$];
  logic [8:0] exp_rd[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       mon_en = 1'b0;
  logic [7:0] tx [32];

  function automatic ev_t mk(input logic [2:0] k, input logic [3:0] pid, input logic [3:0] ep,
                             input logic [9:0] len, input logic d1, input logic [1:0] rs,
                             input logic [10:0] fr);
    return {k, pid, ep, len, d1, rs, fr};
  endfunction

  function automatic ev_t ev_tok(input logic [3:0] pid, input logic [3:0] ep);
    return mk(3'd1, pid, ep, 10'd0, 1'b0, 2'd0, 11'd0);
  endfunction
  function automatic ev_t ev_hs(input logic [3:0] pid);
    return mk(3'd2, pid, 4'd0, 10'd0, 1'b0, 2'd0, 11'd0);
  endfunction
  function automatic ev_t ev_done(input logic [9:0] len, input logic d1);
    return mk(3'd3, 4'd0, 4'd0, len, d1, 2'd0, 11'd0);
  endfunction
  function automatic ev_t ev_drop(input logic [1:0] rs);
    return mk(3'd4, 4'd0, 4'd0, 10'd0, 1'b0, rs, 11'd0);
  endfunction
  function automatic ev_t ev_sof(input logic [10:0] fr);
    return mk(3'd5, 4'd0, 4'd0, 10'd0, 1'b0, 2'd0, fr);
  endfunction

  always @(negedge clk) begin : mon
    int         np;
    ev_t        got, want;
    logic [8:0] gb, wb;
    if (mon_en) begin
      np = 0;
      got = '0;
      if (tok_valid) begin np++; got = ev_tok(tok_pid, tok_endp); end
      if (hs_valid)  begin np++; got = ev_hs(hs_pid); end
      if (pkt_done)  begin np++; got = ev_done(pkt_len, pkt_data1); end
      if (pkt_drop)  begin np++; got = ev_drop(drop_reason); end
      if (sof_valid) begin np++; got = ev_sof(sof_frame); end
      if (np > 1) begin
        n_cmp++; n_err++;
        $display("FAIL event_onehot: %0d simultaneous events, expected 1", np);
      end else if (np == 1) begin
        n_cmp++;
        if (exp_ev.size() == 0) begin
          n_err++;
          $display("FAIL event_unexpected: got %h, expected no event", got);
        end else begin
          want = exp_ev.pop_front();
          if (got !== want) begin
            n_err++;
            $display("FAIL event: got %h, expected %h", got, want);
          end
        end
      end
      if (rd_valid && rd_ready) begin
        gb = {rd_last, rd_data};
        n_cmp++;
        if (exp_rd.size() == 0) begin
          n_err++;
          $display("FAIL read_unexpected: got {last,data}=%h, expected no byte", gb);
        end else begin
          wb = exp_rd.pop_front();
          if (gb !== wb) begin
            n_err++;
            $display("FAIL read_byte: got {last,data}=%h, expected %h", gb, wb);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  task automatic send(input logic [3:0] pid, input int n, input logic [6:0] addr,
                      input logic [3:0] ep, input logic crc, input logic do_eop);
    tick();
    pkt_valid = 1'b1; pkt_sop = 1'b1; pkt_data = {~pid, pid}; pkt_pid = pid;
    for (int i = 0; i < n; i++) begin
      tick();
      pkt_sop = 1'b0; pkt_data = tx[i];
    end
    tick();
    pkt_valid = 1'b0; pkt_sop = 1'b0;
    if (do_eop) begin
      pkt_eop = 1'b1; pkt_dev_addr = addr; pkt_endp = ep; pkt_crc_valid = crc;
      tick();
      pkt_eop = 1'b0;
    end
    tick();
  endtask

  task automatic token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep,
                       input logic crc, input logic accept);
    tx[0] = 8'hA5; tx[1] = 8'h5A;
    if (accept) exp_ev.push_back(ev_tok(pid, ep));
    send(pid, 2, addr, ep, crc, 1'b1);
  endtask

  // payload tx[0..n-3] expected on the read port, last flagged on the final one
  task automatic push_payload(input int n);
    for (int i = 0; i < n - 2; i++) exp_rd.push_back({(i == n - 3), tx[i]});
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_rd.size() != 0 && k < 300) begin tick(); k++; end
    if (exp_rd.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d bytes pending, expected 0", exp_rd.size());
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_ready = 1'b1; cfg_dev_addr = 7'd5;
    pkt_data = '0; pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_pid = '0;
    pkt_dev_addr = '0; pkt_endp = '0; pkt_crc_valid = 1'b0;
    repeat (3) tick();
    chk("rst_tok_valid", 32'(tok_valid), 0);
    chk("rst_hs_valid",  32'(hs_valid), 0);
    chk("rst_pkt_done",  32'(pkt_done), 0);
    chk("rst_pkt_drop",  32'(pkt_drop), 0);
    chk("rst_rd_valid",  32'(rd_valid), 0);
    chk("rst_pkt_len",   32'(pkt_len), 0);
    chk("rst_sof_valid", 32'(sof_valid), 0);
    rst_n = 1'b1; mon_en = 1'b1;
    tick();

    // address filter
    token(OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    token(OUT, 7'd6, 4'd2, 1'b1, 1'b0);
    token(IN,  7'd5, 4'd3, 1'b0, 1'b0);

    // good DATA0, 3 payload bytes
    token(OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'hC1; tx[4] = 8'hC2;
    exp_ev.push_back(ev_done(10'd3, 1'b0)); push_payload(5);
    send(DATA0, 5, 7'd0, 4'd0, 1'b1, 1'b1);
    drain();

    // bad CRC
    token(OUT, 7'd5, 4'd1, 1'b1, 1'b1);
    exp_ev.push_back(ev_drop(2'd0));
    send(DATA1, 5, 7'd0, 4'd0, 1'b0, 1'b1);
    repeat (3) tick();
    chk("badcrc_rd_valid", 32'(rd_valid), 0);

    // not armed, CRC-only payload, runt
    exp_ev.push_back(ev_drop(2'd3));
    send(DATA0, 4, 7'd0, 4'd0, 1'b1, 1'b1);
    token(OUT, 7'd5, 4'd1, 1'b1, 1'b1);
    exp_ev.push_back(ev_done(10'd0, 1'b0));
    send(DATA0, 2, 7'd0, 4'd0, 1'b1, 1'b1);
    token(OUT, 7'd5, 4'd1, 1'b1, 1'b1);
    exp_ev.push_back(ev_drop(2'd2));
    send(DATA0, 1, 7'd0, 4'd0, 1'b1, 1'b1);

    // IN disarms after OUT
    token(OUT, 7'd5, 4'd1, 1'b1, 1'b1);
    token(IN,  7'd5, 4'd1, 1'b1, 1'b1);
    exp_ev.push_back(ev_drop(2'd3));
    send(DATA1, 4, 7'd0, 4'd0, 1'b1, 1'b1);

    // handshakes, malformed token, unknown PID
    exp_ev.push_back(ev_hs(ACK)); send(ACK, 0, 7'd0, 4'd0, 1'b1, 1'b1);
    exp_ev.push_back(ev_hs(NAK)); send(NAK, 0, 7'd0, 4'd0, 1'b1, 1'b1);
    send(OUT, 3, 7'd5, 4'd1, 1'b1, 1'b1);
    send(PRE, 2, 7'd5, 4'd1, 1'b1, 1'b1);

    // lost eop: partial DATA aborted by next sop
    token(OUT, 7'd5, 4'd4, 1'b1, 1'b1);
    tx[0] = 8'hEE; tx[1] = 8'hEF; tx[2] = 8'hF0;
    send(DATA0, 3, 7'd0, 4'd0, 1'b1, 1'b0);
    token(OUT, 7'd5, 4'd4, 1'b1, 1'b1);
    tx[0] = 8'h44; tx[1] = 8'h55; tx[2] = 8'hC3; tx[3] = 8'hC4;
    exp_ev.push_back(ev_done(10'd2, 1'b1)); push_payload(4);
    send(DATA1, 4, 7'd0, 4'd0, 1'b1, 1'b1);
    drain();

    // overflow: 8 committed unread bytes leave room for 7 of the next packet
    rd_ready = 1'b0;
    token(OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tx[i] = 8'hA0 + 8'(i);
    exp_ev.push_back(ev_done(10'd8, 1'b0)); push_payload(10);
    send(DATA0, 10, 7'd0, 4'd0, 1'b1, 1'b1);
    token(OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tx[i] = 8'h60 + 8'(i);
    exp_ev.push_back(ev_drop(2'd1));
    send(DATA1, 10, 7'd0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tx[i] = 8'hA0 + 8'(i);
    rd_ready = 1'b1;
    drain();

    // reading concurrently with the next packet being written
    token(OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) tx[i] = 8'h30 + 8'(i);
    exp_ev.push_back(ev_done(10'd7, 1'b0)); push_payload(9);
    send(DATA0, 9, 7'd0, 4'd0, 1'b1, 1'b1);
    token(OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    exp_ev.push_back(ev_done(10'd7, 1'b1)); push_payload(9);
    send(DATA1, 9, 7'd0, 4'd0, 1'b1, 1'b1);
    drain();

    // reset mid-packet discards committed unread data
    rd_ready = 1'b0;
    token(OUT, 7'd5, 4'd2, 1'b1, 1'b1);
    exp_ev.push_back(ev_done(10'd2, 1'b0));
    send(DATA0, 4, 7'd0, 4'd0, 1'b1, 1'b1);
    chk("pre_reset_rd_valid", 32'(rd_valid), 1);
    send(DATA0, 2, 7'd0, 4'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_rd_valid", 32'(rd_valid), 0);
    rd_ready = 1'b1;
    repeat (4) tick();

    // SOF frame 0x2A5 = {endp 5, addr 0x25}, address filter not applied
`ifdef USB_RX_BUF_SOF_EN
    exp_ev.push_back(ev_sof(11'h2A5));
`endif
    tx[0] = 8'hA5; tx[1] = 8'h2A;
    send(SOF, 2, 7'h25, 4'h5, 1'b1, 1'b1);
    repeat (4) tick();

    drain();
    chk("final_rd_valid", 32'(rd_valid), 0);
    while (exp_ev.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL event_missing: got nothing, expected %h", exp_ev.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
